// File: rtl/conv_layer_sched.sv
`default_nettype none
// ============================================================================
//  Module      : conv_layer_sched
//  Description : Layer sequencer for one convolution stack. For each layer it
//                runs the im2col engine and then the GEMM engine, owns the
//                single shared scratch-memory port, offsets GEMM write
//                addresses per layer, holds idle engines in reset and flags a
//                hung engine through a per-phase watchdog.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_layer_sched #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DATA_WIDTH   = 8,
    parameter int                    NUM_LAYERS   = 4,
    parameter int                    TIMEOUT      = 65535,
    parameter logic [ADDR_WIDTH-1:0] LAYER_STRIDE = 'h0800
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic                          error,
    output logic [$clog2(NUM_LAYERS):0]   layer_idx,
    // im2col engine
    output logic                          i2c_rst_n,
    input  logic                          i2c_done,
    input  logic [ADDR_WIDTH-1:0]         i2c_addr_rd,
    input  logic [ADDR_WIDTH-1:0]         i2c_addr_wr,
    input  logic [DATA_WIDTH-1:0]         i2c_data_wr,
    input  logic                          i2c_wr_en,
    // GEMM engine
    output logic                          gemm_rst_n,
    input  logic                          gemm_done,
    input  logic [ADDR_WIDTH-1:0]         gemm_addr_rd,
    input  logic [ADDR_WIDTH-1:0]         gemm_addr_wr,
    input  logic [DATA_WIDTH-1:0]         gemm_data_wr,
    input  logic                          gemm_wr_en,
    // shared scratch memory
    output logic [ADDR_WIDTH-1:0]         mem_addr_rd,
    output logic [ADDR_WIDTH-1:0]         mem_addr_wr,
    output logic [DATA_WIDTH-1:0]         mem_data_wr,
    output logic                          mem_wr_en
);

    localparam int c_LIDX_W = $clog2(NUM_LAYERS) + 1;
    // Watchdog only ever has to reach TIMEOUT-1
    localparam int c_WDOG_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [c_LIDX_W-1:0] c_LAST_LAYER = c_LIDX_W'(NUM_LAYERS - 1);
    localparam logic [c_WDOG_W-1:0] c_WDOG_LAST  = c_WDOG_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_I2C_ARM  = 3'd1,
        S_I2C_RUN  = 3'd2,
        S_GEMM_ARM = 3'd3,
        S_GEMM_RUN = 3'd4,
        S_DONE     = 3'd5,
        S_ERR      = 3'd6
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_WDOG_W-1:0]   r_wdog;
    logic [c_WDOG_W-1:0]   w_wdog_nxt;
    logic [c_LIDX_W-1:0]   r_layer_idx;
    logic [c_LIDX_W-1:0]   w_layer_nxt;

    // The watchdog is zero only in the first cycle of a RUN phase, while the
    // engine is still leaving reset and its done level is not trustworthy.
    logic                  w_done_valid;
    logic                  w_wdog_expired;
    logic [ADDR_WIDTH-1:0] w_gemm_offset;

    assign w_done_valid   = (r_wdog != '0);
    assign w_wdog_expired = (r_wdog == c_WDOG_LAST);
    assign w_gemm_offset  = ADDR_WIDTH'(r_layer_idx) * LAYER_STRIDE;

    // State, watchdog and layer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_wdog      <= '0;
            r_layer_idx <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_wdog      <= w_wdog_nxt;
            r_layer_idx <= w_layer_nxt;
        end
    end

    // Next-state, watchdog and layer sequencing
    always_comb begin
        w_state_nxt = r_state;
        w_wdog_nxt  = r_wdog;
        w_layer_nxt = r_layer_idx;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt = S_I2C_ARM;
                    w_layer_nxt = '0;
                end
            end
            S_I2C_ARM: begin
                w_state_nxt = S_I2C_RUN;
                w_wdog_nxt  = '0;
            end
            S_I2C_RUN: begin
                // Completion takes priority over a coincident timeout
                if (w_done_valid && i2c_done) begin
                    w_state_nxt = S_GEMM_ARM;
                end else if (w_wdog_expired) begin
                    w_state_nxt = S_ERR;
                end else begin
                    w_wdog_nxt = r_wdog + c_WDOG_W'(1);
                end
            end
            S_GEMM_ARM: begin
                w_state_nxt = S_GEMM_RUN;
                w_wdog_nxt  = '0;
            end
            S_GEMM_RUN: begin
                if (w_done_valid && gemm_done) begin
                    if (r_layer_idx == c_LAST_LAYER) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_I2C_ARM;
                        w_layer_nxt = r_layer_idx + c_LIDX_W'(1);
                    end
                end else if (w_wdog_expired) begin
                    w_state_nxt = S_ERR;
                end else begin
                    w_wdog_nxt = r_wdog + c_WDOG_W'(1);
                end
            end
            S_ERR: begin
                w_state_nxt = S_ERR;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Status and engine resets decoded from the state register
    always_comb begin
        busy       = (r_state == S_I2C_ARM)  || (r_state == S_I2C_RUN) ||
                     (r_state == S_GEMM_ARM) || (r_state == S_GEMM_RUN);
        done       = (r_state == S_DONE);
        error      = (r_state == S_ERR);
        i2c_rst_n  = (r_state == S_I2C_RUN);
        gemm_rst_n = (r_state == S_GEMM_RUN);
    end

    assign layer_idx = r_layer_idx;

    // Shared memory port routed to whichever engine is running, else quiet
    always_comb begin
        mem_addr_rd = '0;
        mem_addr_wr = '0;
        mem_data_wr = '0;
        mem_wr_en   = 1'b0;
        case (r_state)
            S_I2C_RUN: begin
                mem_addr_rd = i2c_addr_rd;
                mem_addr_wr = i2c_addr_wr;
                mem_data_wr = i2c_data_wr;
                mem_wr_en   = i2c_wr_en;
            end
            S_GEMM_RUN: begin
                mem_addr_rd = gemm_addr_rd;
                mem_addr_wr = gemm_addr_wr + w_gemm_offset;
                mem_data_wr = gemm_data_wr;
                mem_wr_en   = gemm_wr_en;
            end
            default: begin
                mem_wr_en   = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_conv_layer_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv_layer_sched
//  Description : Self-checking bench for conv_layer_sched. A phase-level
//                reference model predicts every output each cycle; a monitor
//                compares the DUT against the queued predictions.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_conv_layer_sched;

    localparam int          AW     = 32;
    localparam int          DW     = 8;
    localparam int          NL     = 2;
    localparam int          TO     = 100;
    localparam logic [31:0] STRIDE = 32'h0800;
    localparam int          LW     = $clog2(NL) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          busy, done, error;
    logic [LW-1:0] layer_idx;
    logic          i2c_rst_n, gemm_rst_n;
    logic          i2c_done = 1'b0, gemm_done = 1'b0;
    logic [AW-1:0] i2c_addr_rd = '0, i2c_addr_wr = '0;
    logic [AW-1:0] gemm_addr_rd = '0, gemm_addr_wr = '0;
    logic [DW-1:0] i2c_data_wr = '0, gemm_data_wr = '0;
    logic          i2c_wr_en = 1'b0, gemm_wr_en = 1'b0;
    logic [AW-1:0] mem_addr_rd, mem_addr_wr;
    logic [DW-1:0] mem_data_wr;
    logic          mem_wr_en;

    always #5 clk = ~clk;

    conv_layer_sched #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .NUM_LAYERS  (NL),
        .TIMEOUT     (TO),
        .LAYER_STRIDE(STRIDE)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .layer_idx   (layer_idx),
        .i2c_rst_n   (i2c_rst_n),
        .i2c_done    (i2c_done),
        .i2c_addr_rd (i2c_addr_rd),
        .i2c_addr_wr (i2c_addr_wr),
        .i2c_data_wr (i2c_data_wr),
        .i2c_wr_en   (i2c_wr_en),
        .gemm_rst_n  (gemm_rst_n),
        .gemm_done   (gemm_done),
        .gemm_addr_rd(gemm_addr_rd),
        .gemm_addr_wr(gemm_addr_wr),
        .gemm_data_wr(gemm_data_wr),
        .gemm_wr_en  (gemm_wr_en),
        .mem_addr_rd (mem_addr_rd),
        .mem_addr_wr (mem_addr_wr),
        .mem_data_wr (mem_data_wr),
        .mem_wr_en   (mem_wr_en)
    );

    // ---------------- reference model ----------------
    typedef enum int {M_IDLE, M_ARM_I, M_RUN_I, M_ARM_G, M_RUN_G, M_FIN, M_ERR} mphase_t;

    typedef struct packed {
        logic          busy;
        logic          done;
        logic          error;
        logic [LW-1:0] layer;
        logic          i2c_rstn;
        logic          gemm_rstn;
        logic [AW-1:0] ard;
        logic [AW-1:0] awr;
        logic [DW-1:0] data;
        logic          we;
    } out_t;

    mphase_t m_phase = M_IDLE;
    int      m_layer = 0;
    int      m_cnt   = 0;   // 1-based cycle number inside the current RUN phase

    out_t    exp_q[$];
    out_t    mon_exp, mon_got;
    int      n_checks = 0;
    int      n_pass   = 0;
    int      cyc      = 0;

    // engine behaviour: 0 done after delay, 1 never done, 2 done stuck high, 3 random
    int      i2c_mode = 0, gemm_mode = 0;
    int      i2c_delay = 20, gemm_delay = 20;
    bit      force_6000 = 1'b0;
    bit      arm_count_en = 1'b0;
    int      arm_seen = 0;

    task automatic check(string name, logic [127:0] got, logic [127:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, got, exp);
        else
            n_pass++;
    endtask

    function automatic bit m_busy();
        return (m_phase == M_ARM_I) || (m_phase == M_RUN_I) ||
               (m_phase == M_ARM_G) || (m_phase == M_RUN_G);
    endfunction

    // Advance the model across one clock edge using the inputs seen at that edge
    task automatic model_step();
        if (rst) begin
            m_phase = M_IDLE; m_layer = 0; m_cnt = 0;
        end else begin
            case (m_phase)
                M_IDLE, M_FIN: if (start) begin m_phase = M_ARM_I; m_layer = 0; end
                M_ARM_I: begin m_phase = M_RUN_I; m_cnt = 1; end
                M_RUN_I: begin
                    if (m_cnt > 1 && i2c_done)  m_phase = M_ARM_G;
                    else if (m_cnt >= TO)       m_phase = M_ERR;
                    else                        m_cnt++;
                end
                M_ARM_G: begin m_phase = M_RUN_G; m_cnt = 1; end
                M_RUN_G: begin
                    if (m_cnt > 1 && gemm_done) begin
                        if (m_layer == NL - 1) m_phase = M_FIN;
                        else begin m_layer++; m_phase = M_ARM_I; end
                    end else if (m_cnt >= TO) m_phase = M_ERR;
                    else                      m_cnt++;
                end
                default: ;
            endcase
        end
    endtask

    function automatic out_t model_out();
        out_t o;
        o           = '0;
        o.busy      = m_busy();
        o.done      = (m_phase == M_FIN);
        o.error     = (m_phase == M_ERR);
        o.layer     = LW'(m_layer);
        o.i2c_rstn  = (m_phase == M_RUN_I);
        o.gemm_rstn = (m_phase == M_RUN_G);
        if (m_phase == M_RUN_I) begin
            o.ard = i2c_addr_rd; o.awr = i2c_addr_wr; o.data = i2c_data_wr; o.we = i2c_wr_en;
        end else if (m_phase == M_RUN_G) begin
            o.ard  = gemm_addr_rd;
            o.awr  = gemm_addr_wr + AW'(m_layer) * STRIDE;
            o.data = gemm_data_wr; o.we = gemm_wr_en;
        end
        return o;
    endfunction

    function automatic logic eng_done(int mode, int dly, bit running, int cnt);
        case (mode)
            1:       return 1'b0;
            2:       return 1'b1;
            3:       return running ? ((cnt >= dly) || (cnt == 1 && $urandom_range(0, 1) == 1))
                                    : ($urandom_range(0, 1) == 1);
            default: return running && (cnt >= dly);
        endcase
    endfunction

    task automatic drive_engines();
        if (i2c_mode == 3 && m_phase == M_ARM_I)  i2c_delay  = $urandom_range(1, 12);
        if (gemm_mode == 3 && m_phase == M_ARM_G) gemm_delay = $urandom_range(1, 12);
        i2c_addr_rd  = $urandom;
        i2c_addr_wr  = $urandom;
        i2c_data_wr  = DW'($urandom);
        i2c_wr_en    = $urandom_range(0, 1) == 1;
        gemm_addr_rd = $urandom;
        gemm_addr_wr = force_6000 ? 32'h0000_6000 : $urandom;
        gemm_data_wr = DW'($urandom);
        gemm_wr_en   = $urandom_range(0, 1) == 1;
        i2c_done     = eng_done(i2c_mode,  i2c_delay,  m_phase == M_RUN_I, m_cnt);
        gemm_done    = eng_done(gemm_mode, gemm_delay, m_phase == M_RUN_G, m_cnt);
    endtask

    // One clock: model follows the edge, new inputs applied, prediction queued
    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        drive_engines();
        exp_q.push_back(model_out());
        cyc++;
    endtask

    task automatic steps(int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // Run until the model reaches a phase (and layer, if >=0); optionally jitter start while busy
    task automatic run_until(mphase_t target, int layer, bit jitter, int cap);
        int n;
        n = 0;
        while (!(m_phase == target && (layer < 0 || m_layer == layer)) && n < cap) begin
            step();
            if (jitter) start = m_busy() && ($urandom_range(0, 3) == 0);
            n++;
        end
        if (jitter) start = 1'b0;
        n_checks++;
        if (!(m_phase == target && (layer < 0 || m_layer == layer)))
            $display("FAIL wait_phase_%0d: got phase %0d expected %0d within %0d cycles",
                     target, m_phase, target, cap);
        else
            n_pass++;
    endtask

    // Monitor: compare DUT outputs against the queued prediction for this cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_got = {busy, done, error, layer_idx, i2c_rst_n, gemm_rst_n,
                       mem_addr_rd, mem_addr_wr, mem_data_wr, mem_wr_en};
            check("cycle_outputs", 128'(mon_got), 128'(mon_exp));
            if (force_6000 && gemm_rst_n === 1'b1 && layer_idx === LW'(1))
                check("gemm_layer1_addr", 128'(mem_addr_wr), 128'(32'h0000_6800));
        end
        if (arm_count_en && busy === 1'b1 && i2c_rst_n === 1'b0 && gemm_rst_n === 1'b0)
            arm_seen++;
    end

    initial begin
        // reset
        rst = 1'b1;
        steps(3);
        rst = 1'b0;
        steps(2);

        // nominal two-layer run, fixed GEMM write address, start noise while busy
        force_6000   = 1'b1;
        arm_count_en = 1'b1;
        i2c_mode = 0; gemm_mode = 0; i2c_delay = 20; gemm_delay = 20;
        start = 1'b1;
        step();
        start = 1'b0;
        run_until(M_FIN, -1, 1'b1, 400);
        steps(3);
        arm_count_en = 1'b0;
        force_6000   = 1'b0;
        @(negedge clk); #1;
        check("arm_cycles", 128'(arm_seen), 128'(2 * NL));

        // im2col hangs: watchdog trips, start ignored in ERR, rst recovers
        i2c_mode = 1;
        start = 1'b1; step(); start = 1'b0;
        run_until(M_ERR, -1, 1'b0, 300);
        steps(2);
        start = 1'b1; steps(3); start = 1'b0;
        steps(2);
        rst = 1'b1; step(); rst = 1'b0;
        steps(3);

        // stuck-high im2col done, GEMM done coincident with the last watchdog cycle
        i2c_mode = 2; gemm_mode = 0; gemm_delay = TO;
        start = 1'b1; step(); start = 1'b0;
        run_until(M_FIN, -1, 1'b0, 1000);
        steps(2);

        // reset during layer-1 GEMM, then restart from layer 0
        i2c_mode = 3; gemm_mode = 3;
        start = 1'b1; step(); start = 1'b0;
        run_until(M_RUN_G, 1, 1'b0, 400);
        rst = 1'b1; step(); rst = 1'b0;
        steps(2);
        start = 1'b1; step(); start = 1'b0;
        run_until(M_FIN, -1, 1'b0, 400);
        steps(2);

        // start held high: back-to-back runs
        start = 1'b1;
        step();
        run_until(M_FIN, -1, 1'b0, 400);
        step();
        run_until(M_FIN, -1, 1'b0, 400);
        start = 1'b0;
        steps(3);

        // random traffic with occasional resets
        for (int k = 0; k < 600; k++) begin
            start = ($urandom_range(0, 7) == 0);
            rst   = ($urandom_range(0, 149) == 0);
            step();
        end
        start = 1'b0;
        rst   = 1'b0;
        steps(3);

        @(negedge clk); #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
